// File: rtl/round_key_store_if.sv
// Bus between the AES key expander / round datapath and the round-key store.
// The master drives writes and read requests; the slave answers with ack/data/status.
interface round_key_store_if #(
  parameter int KEY_W = 128,
  parameter int DEPTH = 15,
  parameter int AW    = 4
);
  logic             wr_valid;
  logic [AW-1:0]    wr_addr;
  logic [KEY_W-1:0] wr_key;
  logic             clr_valid;
  logic [1:0]       key_len;
  logic             rd_req;
  logic [AW-1:0]    rd_round;
  logic             rd_ack;
  logic [KEY_W-1:0] rd_key;
  logic             rd_err;
  logic             key_ready;
  logic [DEPTH-1:0] valid_bits;

  modport master (
    output wr_valid, wr_addr, wr_key, clr_valid, key_len, rd_req, rd_round,
    input  rd_ack, rd_key, rd_err, key_ready, valid_bits
  );

  modport slave (
    input  wr_valid, wr_addr, wr_key, clr_valid, key_len, rd_req, rd_round,
    output rd_ack, rd_key, rd_err, key_ready, valid_bits
  );
endinterface

// File: rtl/round_key_store.sv
// Round-key memory with per-entry valid bits; reads stall in WAIT until the
// requested subkey has been written, so cipher rounds can overlap key expansion.
module round_key_store #(
  parameter int KEY_W = 128,
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  round_key_store_if.slave  bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Highest valid round index for a key length (00 has no rounds at all).
  function automatic logic [AW-1:0] max_round(input logic [1:0] len);
    case (len)
      2'b01:   return AW'(4'd10);
      2'b10:   return AW'(4'd12);
      2'b11:   return AW'(4'd14);
      default: return AW'(4'd0);
    endcase
  endfunction

  function automatic logic all_valid(input logic [DEPTH-1:0] v, input logic [1:0] len);
    logic ok;
    ok = (len != 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW'(i) <= max_round(len)) && !v[i]) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  logic [KEY_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_base_s;
  logic [DEPTH-1:0] valid_nxt_s;
  logic             wr_en_s;
  logic             range_err_s;
  logic             hit_s;
  state_t           state_r;
  logic             rd_ack_r;
  logic             rd_err_r;
  logic [KEY_W-1:0] rd_key_r;
  logic             key_ready_r;

  // Decode write enable, read range and hit against the registered valid flags.
  always_comb begin
    wr_en_s     = bus.wr_valid && (bus.wr_addr < AW'(DEPTH));
    range_err_s = (bus.key_len == 2'b00) || (bus.rd_round > max_round(bus.key_len));
    hit_s       = 1'b0;
    if (bus.rd_round < AW'(DEPTH)) begin
      hit_s = valid_r[bus.rd_round];
    end else begin
      hit_s = 1'b0;
    end
  end

  // Clear takes effect first so a same-cycle write survives it.
  always_comb begin
    valid_base_s = valid_r;
    if (bus.clr_valid) begin
      valid_base_s = '0;
    end else begin
      valid_base_s = valid_r;
    end
    valid_nxt_s = valid_base_s | (wr_en_s ? (DEPTH'(1'b1) << bus.wr_addr) : '0);
  end

  // Subkey storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[bus.wr_addr] <= bus.wr_key;
    end
  end

  // Valid flags and the registered all-rounds-present status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r     <= '0;
      key_ready_r <= 1'b0;
    end else begin
      valid_r     <= valid_nxt_s;
      key_ready_r <= all_valid(valid_nxt_s, bus.key_len);
    end
  end

  // Read FSM: ack one cycle after the entry is seen valid, or flag out-of-range.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      rd_ack_r <= 1'b0;
      rd_err_r <= 1'b0;
      rd_key_r <= '0;
    end else begin
      rd_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.rd_req) begin
            if (range_err_s) begin
              rd_ack_r <= 1'b1;
              rd_err_r <= 1'b1;
            end else if (hit_s) begin
              rd_ack_r <= 1'b1;
              rd_err_r <= 1'b0;
              rd_key_r <= mem_r[bus.rd_round];
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!bus.rd_req) begin
            state_r <= ST_IDLE;
          end else if (range_err_s) begin
            rd_ack_r <= 1'b1;
            rd_err_r <= 1'b1;
            state_r  <= ST_IDLE;
          end else if (hit_s) begin
            rd_ack_r <= 1'b1;
            rd_err_r <= 1'b0;
            rd_key_r <= mem_r[bus.rd_round];
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_ack     = rd_ack_r;
  assign bus.rd_err     = rd_err_r;
  assign bus.rd_key     = rd_key_r;
  assign bus.key_ready  = key_ready_r;
  assign bus.valid_bits = valid_r;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: the stimulus side queues expected read
// responses, and an independent monitor checks every rd_ack against them.
module tb_round_key_store;

  localparam int KEY_W = 128;
  localparam int DEPTH = 15;
  localparam int AW    = 4;

  typedef struct {
    logic             err;
    logic [KEY_W-1:0] key;
    int               cyc;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;
  int   ack_cnt;
  int   a0;
  logic [KEY_W-1:0] last_key;
  exp_t sb_q[$];

  round_key_store_if #(.KEY_W(KEY_W), .DEPTH(DEPTH), .AW(AW)) bus ();

  round_key_store #(.KEY_W(KEY_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [KEY_W-1:0] key_of(input int r);
    logic [7:0] b;
    b = 8'(r);
    return {16{b}};
  endfunction

  task automatic chk(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (resetn && bus.rd_ack) begin
      exp_t e;
      ack_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("ack_err", KEY_W'(bus.rd_err), KEY_W'(e.err));
        chk("ack_key", bus.rd_key, e.key);
        chk("ack_cycle", KEY_W'(cyc), KEY_W'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic e, input logic [KEY_W-1:0] k, input int c);
    exp_t x;
    x.err = e;
    x.key = k;
    x.cyc = c;
    sb_q.push_back(x);
  endtask

  task automatic wr(input int a, input logic [KEY_W-1:0] k);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(a);
    bus.wr_key   = k;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_ack(input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (bus.rd_ack) got = 1'b1;
    end
    bus.rd_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: got no ack within %0d cycles expected ack", bound);
    end
  endtask

  task automatic rd(input int r, input logic e, input logic [KEY_W-1:0] k);
    bus.rd_req   = 1'b1;
    bus.rd_round = AW'(r);
    push(e, k, cyc + 1);
    if (!e) last_key = k;
    wait_ack(4);
  endtask

  initial begin
    checks = 0; errors = 0; ack_cnt = 0; last_key = '0;
    resetn = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_key = '0; bus.clr_valid = 1'b0;
    bus.key_len = 2'b00; bus.rd_req = 1'b0; bus.rd_round = '0;
    tick(2);
    chk("rst_ack", KEY_W'(bus.rd_ack), '0);
    chk("rst_err", KEY_W'(bus.rd_err), '0);
    chk("rst_key", bus.rd_key, '0);
    chk("rst_ready", KEY_W'(bus.key_ready), '0);
    chk("rst_valid", KEY_W'(bus.valid_bits), '0);
    resetn = 1'b1;
    tick(1);

    // AES-128 fill, readiness, in-range reads
    bus.key_len = 2'b01;
    for (int r = 0; r <= 10; r++) begin
      if (r == 10) chk("ready_before_last", KEY_W'(bus.key_ready), '0);
      wr(r, key_of(r));
    end
    chk("ready_after_last", KEY_W'(bus.key_ready), KEY_W'(1'b1));
    chk("valid_full128", KEY_W'(bus.valid_bits), KEY_W'(15'h07FF));
    rd(7, 1'b0, key_of(7));
    rd(0, 1'b0, key_of(0));
    rd(10, 1'b0, key_of(10));

    // Out-of-range and no-key reads keep rd_key
    rd(11, 1'b1, last_key);
    rd(12, 1'b1, last_key);
    bus.key_len = 2'b00;
    tick(1);
    chk("ready_nokey", KEY_W'(bus.key_ready), '0);
    rd(0, 1'b1, last_key);

    // AES-192 readiness follows the extra rounds
    bus.key_len = 2'b10;
    tick(1);
    chk("ready_192_partial", KEY_W'(bus.key_ready), '0);
    wr(11, key_of(11));
    wr(12, key_of(12));
    chk("ready_192_full", KEY_W'(bus.key_ready), KEY_W'(1'b1));

    // key_len shrinks under a pending WAIT -> error ack next cycle
    bus.key_len = 2'b11;
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(14);
    tick(3);
    bus.key_len = 2'b01;
    push(1'b1, last_key, cyc + 1);
    wait_ack(4);

    // WAIT resolved by a later write: ack two cycles after the write
    bus.key_len = 2'b11;
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(13);
    tick(2);
    push(1'b0, key_of(13), cyc + 2);
    last_key = key_of(13);
    wr(13, key_of(13));
    wait_ack(4);

    // Simultaneous clear and write
    bus.key_len = 2'b01;
    bus.clr_valid = 1'b1;
    wr(0, {16{8'hA5}});
    bus.clr_valid = 1'b0;
    chk("clr_wr_valid", KEY_W'(bus.valid_bits), KEY_W'(15'h0001));
    chk("clr_wr_ready", KEY_W'(bus.key_ready), '0);

    // Empty entry: wait, then write
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(3);
    tick(3);
    push(1'b0, key_of(3) ^ {16{8'hC3}}, cyc + 2);
    last_key = key_of(3) ^ {16{8'hC3}};
    wr(3, key_of(3) ^ {16{8'hC3}});
    wait_ack(4);

    // Clear during WAIT keeps waiting for the new key's subkey
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(4);
    tick(2);
    bus.clr_valid = 1'b1;
    tick(1);
    bus.clr_valid = 1'b0;
    tick(1);
    push(1'b0, key_of(4), cyc + 2);
    last_key = key_of(4);
    wr(4, key_of(4));
    wait_ack(4);

    // Abandoned request: no ack even when the entry arrives later
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(5);
    tick(2);
    bus.rd_req = 1'b0;
    tick(1);
    a0 = ack_cnt;
    wr(5, key_of(5));
    tick(4);
    chk("abandon_no_ack", KEY_W'(ack_cnt), KEY_W'(a0));
    wr(15, {16{8'hFF}});
    chk("addr15_ignored", KEY_W'(bus.valid_bits), KEY_W'(15'h0030));

    // Async reset between edges while in WAIT
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(0);
    tick(2);
    #2;
    resetn = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    chk("arst_ack", KEY_W'(bus.rd_ack), '0);
    chk("arst_err", KEY_W'(bus.rd_err), '0);
    chk("arst_key", bus.rd_key, '0);
    chk("arst_ready", KEY_W'(bus.key_ready), '0);
    chk("arst_valid", KEY_W'(bus.valid_bits), '0);
    @(negedge clk);
    resetn = 1'b1;
    tick(1);
    bus.rd_req = 1'b1;
    bus.rd_round = AW'(0);
    tick(3);
    push(1'b0, {16{8'h5A}}, cyc + 2);
    wr(0, {16{8'h5A}});
    wait_ack(4);

    tick(2);
    chk("queue_drained", KEY_W'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
